// File: rtl/mdu_ctl.sv
// Iterative multiply/divide unit beside the EX-stage ALU: shift-add MULT/MULTU,
// restoring DIV/DIVU, owns HI/LO and stalls MFHI/MFLO while an operation is in flight.
module mdu_ctl #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [5:0]   Funct,
    input  logic [W-1:0] A,
    input  logic [W-1:0] B,
    input  logic         rd_hilo,
    output logic         busy,
    output logic         stall,
    output logic         done,
    output logic         dz,
    output logic [W-1:0] HI,
    output logic [W-1:0] LO
);

    localparam int            CW   = (W > 1) ? $clog2(W) : 1;
    localparam logic [CW-1:0] LAST = CW'(W - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;

    localparam logic [5:0] F_MULT  = 6'd24;
    localparam logic [5:0] F_MULTU = 6'd25;
    localparam logic [5:0] F_DIV   = 6'd26;
    localparam logic [5:0] F_DIVU  = 6'd27;

    logic [1:0]     r_state;
    logic [CW-1:0]  r_count;
    logic           r_done;
    logic           r_dz;
    logic [W-1:0]   r_hi;
    logic [W-1:0]   r_lo;

    logic           r_is_div;
    logic           r_sa;
    logic           r_sb;
    logic           r_dz_op;
    logic [W-1:0]   r_opnd;
    logic [W-1:0]   r_a_lat;
    logic [2*W:0]   r_acc;

    logic           w_accept;
    logic           w_signed;
    logic           w_div;
    logic           w_sa;
    logic           w_sb;
    logic [W-1:0]   w_abs_a;
    logic [W-1:0]   w_abs_b;
    logic [W:0]     w_sum;
    logic [2*W:0]   w_mul_next;
    logic [2*W:0]   w_shl;
    logic [W+1:0]   w_trial;
    logic [2*W:0]   w_div_next;
    logic [2*W-1:0] w_prod;
    logic [W-1:0]   w_quo;
    logic [W-1:0]   w_rem;

    assign w_accept = start && (Funct == F_MULT || Funct == F_MULTU ||
                                Funct == F_DIV  || Funct == F_DIVU);
    assign w_signed = (Funct == F_MULT) || (Funct == F_DIV);
    assign w_div    = (Funct == F_DIV)  || (Funct == F_DIVU);
    assign w_sa     = w_signed & A[W-1];
    assign w_sb     = w_signed & B[W-1];
    assign w_abs_a  = w_sa ? -A : A;
    assign w_abs_b  = w_sb ? -B : B;

    // Multiply: accumulator high part is W+1 bits so the add never loses its carry.
    assign w_sum      = r_acc[2*W:W] + {1'b0, r_opnd};
    assign w_mul_next = {(r_acc[0] ? w_sum : r_acc[2*W:W]), r_acc[W-1:0]} >> 1;

    // Divide: remainder in the high part, quotient shifts in at the LSB.
    assign w_shl      = {r_acc[2*W-1:0], 1'b0};
    assign w_trial    = {1'b0, w_shl[2*W:W]} - {2'b00, r_opnd};
    assign w_div_next = w_trial[W+1] ? w_shl : {w_trial[W:0], w_shl[W-1:1], 1'b1};

    assign w_prod = (r_sa ^ r_sb) ? -r_acc[2*W-1:0] : r_acc[2*W-1:0];
    assign w_quo  = (r_sa ^ r_sb) ? -r_acc[W-1:0]   : r_acc[W-1:0];
    assign w_rem  = r_sa          ? -r_acc[2*W-1:W] : r_acc[2*W-1:W];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_count <= '0;
            r_done  <= 1'b0;
            r_dz    <= 1'b0;
            r_hi    <= '0;
            r_lo    <= '0;
        end else begin
            r_done <= (r_state == S_FIX);
            if (w_accept) begin
                r_dz <= 1'b0;
            end
            // The finishing operation's write lands even when a new start arrives on the FIX edge.
            if (r_state == S_FIX) begin
                if (r_dz_op) begin
                    r_hi <= r_a_lat;
                    r_lo <= '1;
                    r_dz <= 1'b1;
                end else if (r_is_div) begin
                    r_hi <= w_rem;
                    r_lo <= w_quo;
                end else begin
                    r_hi <= w_prod[2*W-1:W];
                    r_lo <= w_prod[W-1:0];
                end
            end
            if (w_accept) begin
                r_count <= '0;
                r_state <= (w_div && B == '0) ? S_FIX : S_RUN;
            end else begin
                case (r_state)
                    S_RUN: begin
                        r_count <= r_count + CW'(1);
                        if (r_count == LAST) begin
                            r_state <= S_FIX;
                        end
                    end
                    S_FIX:   r_state <= S_IDLE;
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    // NOTE: operand/accumulator registers carry no reset; they are always loaded on accept before use.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_is_div <= w_div;
            r_sa     <= w_sa;
            r_sb     <= w_sb;
            r_dz_op  <= w_div && (B == '0);
            r_a_lat  <= A;
            r_opnd   <= w_div ? w_abs_b : w_abs_a;
            r_acc    <= {{(W+1){1'b0}}, (w_div ? w_abs_a : w_abs_b)};
        end else if (r_state == S_RUN) begin
            r_acc <= r_is_div ? w_div_next : w_mul_next;
        end
    end

    assign busy  = (r_state != S_IDLE);
    assign stall = busy & rd_hilo;
    assign done  = r_done;
    assign dz    = r_dz;
    assign HI    = r_hi;
    assign LO    = r_lo;

endmodule
